uart_line_buffer: RTL

- Sits between the UART receive block and the alpha display decoders.
- Accepts each received byte through a single-clock handshake and keeps the last NUM_DIGITS printable characters as a scrolling line.
- Interprets backspace and line-end control codes, and counts receiver error events.
- Generalises single-character capture to an N-digit line: fully synchronous, no clocking on data_ready.

---
 rtl/uart_line_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_line_buffer.sv
// Scrolling N-character line buffer fed by a UART receiver handshake, with error-event counting.
// Optional: define FRAME_ERR_SUBST_EN to insert '?' into the line on a framing-error edge while idle.
module uart_line_buffer #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter logic [7:0]  FILL_CHAR  = 8'h20,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               data_ready,
  input  logic [7:0]                         rx_data,
  input  logic                               overrun_error,
  input  logic                               framing_error,
  output logic                               data_read,
  output logic [NUM_DIGITS*8-1:0]            disp_chars,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    char_count,
  output logic [ERR_W-1:0]                   err_count,
  output logic                               new_char
);

  localparam int unsigned LINE_W = NUM_DIGITS * 8;
  localparam int unsigned CNT_W  = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               data_read_q, data_read_d;
  logic               new_char_q, new_char_d;
  logic               ovr_q, ovr_d;
  logic               frm_q, frm_d;

  logic               capture;
  logic [7:0]         byte_c;
  logic               err_edge;

  // Next-state, line update and error counting
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    data_read_d = 1'b0;
    new_char_d  = 1'b0;
    ovr_d       = overrun_error;
    frm_d       = framing_error;
    capture     = 1'b0;
    byte_c      = rx_data;

    err_edge = (overrun_error & ~ovr_q) | (framing_error & ~frm_q);
    if (err_edge && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (data_ready) begin
          capture     = 1'b1;
          data_read_d = 1'b1;
          state_d     = ACK;
        end
`ifdef FRAME_ERR_SUBST_EN
        else if (framing_error && !frm_q) begin
          capture = 1'b1;
          byte_c  = 8'h3F;
        end
`endif
      end
      ACK:     state_d = DRAIN;
      DRAIN:   if (!data_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Slot 0 is the newest character; printable bytes push older ones toward the top slot
    if (capture) begin
      if ((byte_c >= 8'h20) && (byte_c <= 8'h7E)) begin
        line_d     = {line_q[LINE_W-9:0], byte_c};
        new_char_d = 1'b1;
        if (cnt_q != CNT_W'(NUM_DIGITS)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (byte_c == 8'h08) begin
        if (cnt_q != '0) begin
          line_d     = {FILL_CHAR, line_q[LINE_W-1:8]};
          cnt_d      = cnt_q - CNT_W'(1);
          new_char_d = 1'b1;
        end
      end else if ((byte_c == 8'h0D) || (byte_c == 8'h0A)) begin
        line_d     = {NUM_DIGITS{FILL_CHAR}};
        cnt_d      = '0;
        new_char_d = (cnt_q != '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= {NUM_DIGITS{FILL_CHAR}};
      cnt_q       <= '0;
      err_q       <= '0;
      data_read_q <= 1'b0;
      new_char_q  <= 1'b0;
      ovr_q       <= 1'b0;
      frm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      data_read_q <= data_read_d;
      new_char_q  <= new_char_d;
      ovr_q       <= ovr_d;
      frm_q       <= frm_d;
    end
  end

  assign data_read  = data_read_q;
  assign disp_chars = line_q;
  assign char_count = cnt_q;
  assign err_count  = err_q;
  assign new_char   = new_char_q;

endmodule
